fetch_issue: RTL and testbench

FETCH_ISSUE -- requirements
Module: fetch_issue

---
 rtl/fetch_issue_if.sv | 24 ++
 rtl/fetch_issue.sv | 119 +++++++++++
 tb/tb_fetch_issue.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/fetch_issue_if.sv
// Fetch/issue bus: program-memory read port, decoder issue port and control-path redirect.
interface fetch_issue_if;
  logic       pm_rd;
  logic [7:0] pm_addr;
  logic [7:0] pm_data;
  logic       stall;
  logic       redirect;
  logic [7:0] redirect_addr;
  logic [7:0] opcode;
  logic [7:0] operand;
  logic       issue_valid;
  logic [7:0] pc_next;
  logic       illegal;

  modport master (
    output pm_rd, pm_addr, opcode, operand, issue_valid, pc_next, illegal,
    input  pm_data, stall, redirect, redirect_addr
  );

  modport slave (
    input  pm_rd, pm_addr, opcode, operand, issue_valid, pc_next, illegal,
    output pm_data, stall, redirect, redirect_addr
  );
endinterface

// File: rtl/fetch_issue.sv
// Byte fetcher with 3-deep prefetch FIFO; issues 1/2-byte instructions, 3 cycles reset-to-first-issue.
// stall freezes the output slot and lets the FIFO fill; FETCH_ILLEGAL_TRAP_EN turns 1111_xxxx into NOP + illegal.
module fetch_issue #(
  parameter logic [7:0] PC_RST = 8'h00
) (
  input logic          clk,
  input logic          rst_n,
  fetch_issue_if.master bus
);

  logic [7:0] fifo [3];
  logic [7:0] fifo_nxt [3];
  logic [7:0] v [5];
  logic [1:0] occ;
  logic [1:0] occ_nxt;
  logic       inflight;
  logic       run;
  logic [7:0] fetch_pc;
  logic [7:0] head_pc;
  logic [7:0] opcode_q;
  logic [7:0] operand_q;
  logic [7:0] pc_next_q;
  logic       issue_valid_q;
  logic [2:0] avail;
  logic [2:0] len;
  logic [2:0] n;
  logic       two;
  logic       slot_free;
  logic       do_issue;
  logic       pm_rd_i;
  logic       trap;

  function automatic logic is_two(input logic [7:0] op);
    return (op == 8'h03) || (op == 8'h05) ||
           (op[7:3] == 5'b00001) || (op[7:3] == 5'b00110) || (op[7:3] == 5'b01011) ||
           (op[7] && op[3] && (op[6:4] != 3'b111));
  endfunction

  // Byte view: buffered bytes followed by the arriving read response (bypass).
  always_comb begin
    for (int i = 0; i < 5; i++) v[i] = 8'h00;
    for (int i = 0; i < 3; i++) if (2'(i) < occ) v[i] = fifo[i];
    if (inflight) v[occ] = bus.pm_data;
  end

  assign avail     = {1'b0, occ} + {2'b00, inflight};
  assign two       = is_two(v[0]);
  assign len       = two ? 3'd2 : 3'd1;
  assign slot_free = !issue_valid_q || !bus.stall;
  assign do_issue  = slot_free && (avail >= len);
  assign n         = do_issue ? len : 3'd0;
  assign occ_nxt   = 2'(avail - n);
  assign pm_rd_i   = run && (avail < 3'd3);

  always_comb begin
    for (int i = 0; i < 3; i++) fifo_nxt[i] = v[3'(i) + n];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) fifo[i] <= 8'h00;
      occ           <= 2'd0;
      inflight      <= 1'b0;
      run           <= 1'b0;
      fetch_pc      <= PC_RST;
      head_pc       <= PC_RST;
      opcode_q      <= 8'h00;
      operand_q     <= 8'h00;
      pc_next_q     <= PC_RST;
      issue_valid_q <= 1'b0;
    end else begin
      run <= 1'b1;
      if (bus.redirect) begin
        occ           <= 2'd0;
        inflight      <= 1'b0;
        fetch_pc      <= bus.redirect_addr;
        head_pc       <= bus.redirect_addr;
        issue_valid_q <= 1'b0;
      end else begin
        fifo     <= fifo_nxt;
        occ      <= occ_nxt;
        inflight <= pm_rd_i;
        if (pm_rd_i) fetch_pc <= fetch_pc + 8'd1;
        if (do_issue) begin
          opcode_q      <= trap ? 8'h00 : v[0];
          operand_q     <= two ? v[1] : 8'h00;
          pc_next_q     <= head_pc + {5'b0, len};
          head_pc       <= head_pc + {5'b0, len};
          issue_valid_q <= 1'b1;
        end else if (slot_free) begin
          issue_valid_q <= 1'b0;
        end
      end
    end
  end

`ifdef FETCH_ILLEGAL_TRAP_EN
  logic illegal_q;
  assign trap = &v[0][7:4];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) illegal_q <= 1'b0;
    else        illegal_q <= !bus.redirect && do_issue && trap;
  end

  assign bus.illegal = illegal_q;
`else
  assign trap        = 1'b0;
  assign bus.illegal = 1'b0;
`endif

  assign bus.pm_rd       = pm_rd_i;
  assign bus.pm_addr     = fetch_pc;
  assign bus.opcode      = opcode_q;
  assign bus.operand     = operand_q;
  assign bus.pc_next     = pc_next_q;
  assign bus.issue_valid = issue_valid_q;

endmodule

// File: tb/tb_fetch_issue.sv
// Directed bench for fetch_issue: synchronous byte memory model, hand-computed expectations per cycle.
module tb_fetch_issue;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [7:0] mem [256];
  int n_cmp = 0;
  int n_bad = 0;

  fetch_issue_if bus ();

  fetch_issue #(.PC_RST(8'h00)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) bus.pm_data <= mem[bus.pm_addr];

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %02h expected %02h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill();
    for (int i = 0; i < 256; i++) mem[i] = 8'h10 + 8'(i & 15);
  endtask

  // Holds reset two edges, then releases on a falling edge; next rising edge is cycle 1.
  task automatic do_reset();
    rst_n = 1'b0;
    bus.stall = 1'b0;
    bus.redirect = 1'b0;
    bus.redirect_addr = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    bus.pm_data = 8'h00;
    fill();
    do_reset();
    chk("rst_pm_rd", 8'(bus.pm_rd), 8'h00);
    chk("rst_pm_addr", bus.pm_addr, 8'h00);
    chk("rst_opcode", bus.opcode, 8'h00);
    chk("rst_operand", bus.operand, 8'h00);
    chk("rst_pc_next", bus.pc_next, 8'h00);
    chk("rst_valid", 8'(bus.issue_valid), 8'h00);
    chk("rst_illegal", 8'(bus.illegal), 8'h00);

    // NOP then 01: reads in cycles 1,2; first issue in cycle 3
    fill(); mem[0] = 8'h00; mem[1] = 8'h01;
    do_reset();
    tick();
    chk("c1_pm_rd", 8'(bus.pm_rd), 8'h01);
    chk("c1_pm_addr", bus.pm_addr, 8'h00);
    chk("c1_valid", 8'(bus.issue_valid), 8'h00);
    tick();
    chk("c2_pm_rd", 8'(bus.pm_rd), 8'h01);
    chk("c2_pm_addr", bus.pm_addr, 8'h01);
    chk("c2_valid", 8'(bus.issue_valid), 8'h00);
    tick();
    chk("c3_valid", 8'(bus.issue_valid), 8'h01);
    chk("c3_opcode", bus.opcode, 8'h00);
    chk("c3_operand", bus.operand, 8'h00);
    chk("c3_pc_next", bus.pc_next, 8'h01);
    tick();
    chk("c4_opcode", bus.opcode, 8'h01);
    chk("c4_pc_next", bus.pc_next, 8'h02);

    // MVI r3,7F: two-byte, no partial issue
    fill(); mem[0] = 8'h5B; mem[1] = 8'h7F;
    do_reset();
    repeat (3) tick();
    chk("mvi_no_partial", 8'(bus.issue_valid), 8'h00);
    tick();
    chk("mvi_valid", 8'(bus.issue_valid), 8'h01);
    chk("mvi_opcode", bus.opcode, 8'h5B);
    chk("mvi_operand", bus.operand, 8'h7F);
    chk("mvi_pc_next", bus.pc_next, 8'h02);
    tick();
    chk("mvi_next_opcode", bus.opcode, 8'h12);
    chk("mvi_next_pc", bus.pc_next, 8'h03);

    // Stall with the FIFO filling to 3 bytes
    fill();
    do_reset();
    bus.stall = 1'b1;
    repeat (3) tick();
    chk("stl_first", bus.opcode, 8'h10);
    for (int k = 4; k <= 7; k++) begin
      tick();
      chk("stl_hold_opcode", bus.opcode, 8'h10);
      chk("stl_hold_pc", bus.pc_next, 8'h01);
      chk("stl_hold_valid", 8'(bus.issue_valid), 8'h01);
      if (k >= 6) chk("stl_full_no_rd", 8'(bus.pm_rd), 8'h00);
    end
    bus.stall = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("stl_drain_opcode", bus.opcode, 8'h11 + 8'(k));
      chk("stl_drain_operand", bus.operand, 8'h00);
      chk("stl_drain_pc", bus.pc_next, 8'h02 + 8'(k));
      chk("stl_drain_valid", 8'(bus.issue_valid), 8'h01);
    end

    // Redirect to 40 with a read in flight
    fill(); mem[8'h40] = 8'h20;
    do_reset();
    repeat (2) tick();
    bus.redirect = 1'b1;
    bus.redirect_addr = 8'h40;
    tick();
    bus.redirect = 1'b0;
    chk("rdr_valid_clr", 8'(bus.issue_valid), 8'h00);
    chk("rdr_pm_rd", 8'(bus.pm_rd), 8'h01);
    chk("rdr_pm_addr", bus.pm_addr, 8'h40);
    tick();
    chk("rdr_dropped", 8'(bus.issue_valid), 8'h00);
    tick();
    chk("rdr_opcode", bus.opcode, 8'h20);
    chk("rdr_pc_next", bus.pc_next, 8'h41);
    chk("rdr_valid", 8'(bus.issue_valid), 8'h01);

    // Reset asserted mid-fetch clears state at once
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 8'(bus.issue_valid), 8'h00);
    chk("mid_rst_pm_rd", 8'(bus.pm_rd), 8'h00);
    chk("mid_rst_pm_addr", bus.pm_addr, 8'h00);
    fill();
    do_reset();
    tick();
    chk("mid_rst_first_rd", 8'(bus.pm_rd), 8'h01);

    // Address wrap: 88 at FF, od at 00
    fill(); mem[8'hFF] = 8'h88; mem[0] = 8'h10;
    do_reset();
    bus.redirect = 1'b1;
    bus.redirect_addr = 8'hFF;
    tick();
    bus.redirect = 1'b0;
    chk("wrap_pm_addr", bus.pm_addr, 8'hFF);
    repeat (2) tick();
    chk("wrap_no_partial", 8'(bus.issue_valid), 8'h00);
    tick();
    chk("wrap_opcode", bus.opcode, 8'h88);
    chk("wrap_operand", bus.operand, 8'h10);
    chk("wrap_pc_next", bus.pc_next, 8'h01);

    // 1111_xxxx opcode
    fill(); mem[0] = 8'hF3;
    do_reset();
    repeat (3) tick();
`ifdef FETCH_ILLEGAL_TRAP_EN
    chk("f3_opcode", bus.opcode, 8'h00);
    chk("f3_illegal", 8'(bus.illegal), 8'h01);
`else
    chk("f3_opcode", bus.opcode, 8'hF3);
    chk("f3_illegal", 8'(bus.illegal), 8'h00);
`endif
    chk("f3_pc_next", bus.pc_next, 8'h01);
    tick();
    chk("f3_illegal_once", 8'(bus.illegal), 8'h00);
    chk("f3_next_opcode", bus.opcode, 8'h11);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
